// File: rtl/regfile_arbiter.sv
// Round-robin arbiter with grant lock in front of a 2R/1W register file.
// Registers the winning request into the file and returns tagged, registered read responses.
module regfile_arbiter #(
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned NUM_REGS_LOG = 3,
  parameter int unsigned DATA_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n_i,
  // Port A
  input  logic                    a_valid_i,
  output logic                    a_ready_o,
  input  logic                    a_wen_i,
  input  logic                    a_lock_i,
  input  logic [NUM_REGS_LOG-1:0] a_ra0_i,
  input  logic [NUM_REGS_LOG-1:0] a_ra1_i,
  input  logic [NUM_REGS_LOG-1:0] a_wa_i,
  input  logic [DATA_WIDTH-1:0]   a_wd_i,
  output logic                    a_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   a_rd0_o,
  output logic [DATA_WIDTH-1:0]   a_rd1_o,
  // Port B
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic                    b_wen_i,
  input  logic                    b_lock_i,
  input  logic [NUM_REGS_LOG-1:0] b_ra0_i,
  input  logic [NUM_REGS_LOG-1:0] b_ra1_i,
  input  logic [NUM_REGS_LOG-1:0] b_wa_i,
  input  logic [DATA_WIDTH-1:0]   b_wd_i,
  output logic                    b_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   b_rd0_o,
  output logic [DATA_WIDTH-1:0]   b_rd1_o,
  // Register file
  output logic                    rf_wen_o,
  output logic [NUM_REGS_LOG-1:0] rf_ra0_o,
  output logic [NUM_REGS_LOG-1:0] rf_ra1_o,
  output logic [NUM_REGS_LOG-1:0] rf_wa_o,
  output logic [DATA_WIDTH-1:0]   rf_wd_o,
  input  logic [DATA_WIDTH-1:0]   rf_rd0_i,
  input  logic [DATA_WIDTH-1:0]   rf_rd1_i
);

  if (NUM_REGS != (1 << NUM_REGS_LOG)) begin : gen_param_check
    $error("NUM_REGS must equal 2**NUM_REGS_LOG");
  end

  typedef enum logic [1:0] {StUnlocked, StLockA, StLockB} state_e;

  state_e                  state_q, state_d;
  logic                    prio_q, prio_d;  // 0: A wins a tie, 1: B wins a tie
  logic                    grant_a, grant_b, accept;
  logic                    elig_a, elig_b;

  logic                    rf_wen_q, rf_wen_d;
  logic [NUM_REGS_LOG-1:0] rf_ra0_q, rf_ra0_d, rf_ra1_q, rf_ra1_d, rf_wa_q, rf_wa_d;
  logic [DATA_WIDTH-1:0]   rf_wd_q, rf_wd_d;

  // Stage 1 tag: beat on the rf bus this cycle and which port issued it
  logic                    s1_valid_q, s1_valid_d, s1_port_q, s1_port_d;
  logic                    a_rsp_q, a_rsp_d, b_rsp_q, b_rsp_d;
  logic [DATA_WIDTH-1:0]   a_rd0_q, a_rd0_d, a_rd1_q, a_rd1_d;
  logic [DATA_WIDTH-1:0]   b_rd0_q, b_rd0_d, b_rd1_q, b_rd1_d;

  always_comb begin
    elig_a  = a_valid_i && (state_q != StLockB);
    elig_b  = b_valid_i && (state_q != StLockA);
    grant_a = elig_a && (!elig_b || !prio_q);
    grant_b = elig_b && !grant_a;
    accept  = grant_a || grant_b;

    state_d = state_q;
    prio_d  = prio_q;
    if (grant_a) begin
      state_d = a_lock_i ? StLockA : StUnlocked;
      if (!a_lock_i) prio_d = 1'b1;
    end else if (grant_b) begin
      state_d = b_lock_i ? StLockB : StUnlocked;
      if (!b_lock_i) prio_d = 1'b0;
    end
  end

  always_comb begin
    rf_wen_d = 1'b0;
    rf_ra0_d = rf_ra0_q;
    rf_ra1_d = rf_ra1_q;
    rf_wa_d  = rf_wa_q;
    rf_wd_d  = rf_wd_q;
    if (grant_a) begin
      rf_wen_d = a_wen_i;
      rf_ra0_d = a_ra0_i;
      rf_ra1_d = a_ra1_i;
      rf_wa_d  = a_wa_i;
      rf_wd_d  = a_wd_i;
    end else if (grant_b) begin
      rf_wen_d = b_wen_i;
      rf_ra0_d = b_ra0_i;
      rf_ra1_d = b_ra1_i;
      rf_wa_d  = b_wa_i;
      rf_wd_d  = b_wd_i;
    end
  end

  // Read data is captured on the same edge that commits the beat's own write, so it is pre-write.
  always_comb begin
    s1_valid_d = accept;
    s1_port_d  = grant_b;
    a_rsp_d    = s1_valid_q && !s1_port_q;
    b_rsp_d    = s1_valid_q && s1_port_q;
    a_rd0_d    = a_rsp_d ? rf_rd0_i : a_rd0_q;
    a_rd1_d    = a_rsp_d ? rf_rd1_i : a_rd1_q;
    b_rd0_d    = b_rsp_d ? rf_rd0_i : b_rd0_q;
    b_rd1_d    = b_rsp_d ? rf_rd1_i : b_rd1_q;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StUnlocked;
      prio_q     <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_ra0_q   <= '0;
      rf_ra1_q   <= '0;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_port_q  <= 1'b0;
      a_rsp_q    <= 1'b0;
      b_rsp_q    <= 1'b0;
      a_rd0_q    <= '0;
      a_rd1_q    <= '0;
      b_rd0_q    <= '0;
      b_rd1_q    <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      rf_wen_q   <= rf_wen_d;
      rf_ra0_q   <= rf_ra0_d;
      rf_ra1_q   <= rf_ra1_d;
      rf_wa_q    <= rf_wa_d;
      rf_wd_q    <= rf_wd_d;
      s1_valid_q <= s1_valid_d;
      s1_port_q  <= s1_port_d;
      a_rsp_q    <= a_rsp_d;
      b_rsp_q    <= b_rsp_d;
      a_rd0_q    <= a_rd0_d;
      a_rd1_q    <= a_rd1_d;
      b_rd0_q    <= b_rd0_d;
      b_rd1_q    <= b_rd1_d;
    end
  end

  assign a_ready_o     = grant_a && rst_n_i;
  assign b_ready_o     = grant_b && rst_n_i;
  assign rf_wen_o      = rf_wen_q;
  assign rf_ra0_o      = rf_ra0_q;
  assign rf_ra1_o      = rf_ra1_q;
  assign rf_wa_o       = rf_wa_q;
  assign rf_wd_o       = rf_wd_q;
  assign a_rsp_valid_o = a_rsp_q;
  assign b_rsp_valid_o = b_rsp_q;
  assign a_rd0_o       = a_rd0_q;
  assign a_rd1_o       = a_rd1_q;
  assign b_rd0_o       = b_rd0_q;
  assign b_rd1_o       = b_rd1_q;

endmodule
